// File: rtl/sensor_debounce_latch.sv
// Sensor push-button conditioner: 2-FF synchroniser, 4-state debounce FSM,
// press edge pulse and sticky car_waiting request. Optional SENSOR_PRESS_COUNT_EN adds press_count.
module sensor_debounce_latch #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_raw,
    input  logic       clear_req,
    output logic       sensor_db,
    output logic       press_pulse,
    output logic       car_waiting
`ifdef SENSOR_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             cw_q;
    logic             cw_d;
    logic             cnt_done_s;

    assign cnt_done_s = (cnt_q == CNT_MAX);

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sensor_raw;
            s2_q <= s1_q;
        end
    end

    // FSM state and stability counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; counter restarts on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_done_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s2_q) begin
                    state_d = ST_REL_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_REL_CHK: begin
                if (s2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_done_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output next values; a press set beats a same-cycle clear
    always_comb begin
        db_d    = db_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_PRESS_CHK: begin
                if (s2_q && cnt_done_s) begin
                    db_d    = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    db_d    = db_q;
                end
            end
            ST_REL_CHK: begin
                if (!s2_q && cnt_done_s) begin
                    db_d = 1'b0;
                end else begin
                    db_d = db_q;
                end
            end
            default: begin
                db_d = db_q;
            end
        endcase
        if (pulse_d) begin
            cw_d = 1'b1;
        end else if (clear_req) begin
            cw_d = 1'b0;
        end else begin
            cw_d = cw_q;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            cw_q    <= 1'b0;
        end else begin
            db_q    <= db_d;
            pulse_q <= pulse_d;
            cw_q    <= cw_d;
        end
    end

    assign sensor_db   = db_q;
    assign press_pulse = pulse_q;
    assign car_waiting = cw_q;

`ifdef SENSOR_PRESS_COUNT_EN
    logic [7:0] press_cnt_q;

    // Free-running press counter, wraps 255 -> 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt_q <= 8'd0;
        end else if (pulse_d) begin
            press_cnt_q <= press_cnt_q + 8'd1;
        end else begin
            press_cnt_q <= press_cnt_q;
        end
    end

    assign press_count = press_cnt_q;
`endif

endmodule

// File: tb/tb_sensor_debounce_latch.sv
// Scoreboard bench for sensor_debounce_latch with DEBOUNCE_CYCLES=4; expected
// outputs come from a run-length model of the debounce rule.
module tb_sensor_debounce_latch;

    localparam int D = 4;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic sensor_raw = 1'b0;
    logic clear_req  = 1'b0;
    logic sensor_db;
    logic press_pulse;
    logic car_waiting;
    logic [7:0] cnt_obs;
`ifdef SENSOR_PRESS_COUNT_EN
    logic [7:0] press_count;
    assign cnt_obs = press_count;
`else
    assign cnt_obs = 8'd0;
`endif

    always #5 clk = ~clk;

    sensor_debounce_latch #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_raw  (sensor_raw),
        .clear_req   (clear_req),
        .sensor_db   (sensor_db),
        .press_pulse (press_pulse),
        .car_waiting (car_waiting)
`ifdef SENSOR_PRESS_COUNT_EN
        ,
        .press_count (press_count)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: synchroniser delay plus run-length of samples differing from db
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0, m_pulse = 1'b0, m_cw = 1'b0;
    int         m_run = 0;
    logic [7:0] m_cnt = 8'd0;
    logic [10:0] sb_q[$];

    task automatic model_edge(input logic raw, input logic clr);
        if (!reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_pulse = 1'b0;
            m_cw = 1'b0; m_run = 0; m_cnt = 8'd0;
        end else begin
            m_pulse = 1'b0;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_db    = ~m_db;
                    m_run   = 0;
                    m_pulse = m_db;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = raw;
            if (m_pulse) m_cw = 1'b1;
            else if (clr) m_cw = 1'b0;
            if (m_pulse) m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic step(input logic raw, input logic clr);
        logic [10:0] e;
        sensor_raw = raw;
        clear_req  = clr;
        model_edge(raw, clr);
        sb_q.push_back({m_db, m_pulse, m_cw, m_cnt});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sensor_db", {31'd0, sensor_db}, {31'd0, e[10]});
            chk("press_pulse", {31'd0, press_pulse}, {31'd0, e[9]});
            chk("car_waiting", {31'd0, car_waiting}, {31'd0, e[8]});
`ifdef SENSOR_PRESS_COUNT_EN
            chk("press_count", {24'd0, cnt_obs}, {24'd0, e[7:0]});
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {29'd0, sensor_db, press_pulse, car_waiting}, 32'd0);
    endtask

    // Drive raw until sensor_db reaches target (bounded) and check the edge count
    task automatic wait_db(input logic raw, input logic target, input string tag);
        int n = 0;
        do begin
            step(raw, 1'b0);
            n++;
        end while (sensor_db !== target && n < 20);
        chk(tag, n, 32'd7);
    endtask

    initial begin
        logic r;
        // 1: reset held 3 cycles
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        reset = 1'b1;
        check_zero("reset_outputs");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // 2: clean press, rise after 7 edges, pulse one cycle
        wait_db(1'b1, 1'b1, "rise_latency");
        chk("pulse_on_rise", {31'd0, press_pulse}, 32'd1);
        step(1'b1, 1'b0);
        chk("pulse_one_cycle", {31'd0, press_pulse}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // 4: clean release, car_waiting held, then cleared
        wait_db(1'b0, 1'b0, "fall_latency");
        chk("cw_sticky", {31'd0, car_waiting}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("cw_cleared", {31'd0, car_waiting}, 32'd0);
        step(1'b0, 1'b1);

        // 3: bouncing input rejected
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        check_zero("glitch_rejected");

        // 5: clear_req coincident with the press edge
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("set_wins", {30'd0, press_pulse, car_waiting}, 32'd3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // 6: reset during PRESS_CHK with button held
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        step(1'b1, 1'b0);
        reset = 1'b1;
        check_zero("after_release");
        wait_db(1'b1, 1'b1, "repress_latency");
        chk("repress_pulse", {31'd0, press_pulse}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Random raw with persistence and random clears
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = ~r;
            step(r, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

`ifdef SENSOR_PRESS_COUNT_EN
        reset = 1'b0;
        step(1'b0, 1'b0);
        reset = 1'b1;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        end
        chk("count_wrap", {24'd0, cnt_obs}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
